spi_flash_target: RTL

//  SPI mode-0 target that emulates a serial NOR flash on the far end of our spi_tx initiator.

---
 rtl/spi_flash_target_pkg.sv | 19 +
 rtl/spi_flash_target_sync_edge.sv | 43 ++++
 rtl/spi_flash_target.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_target_pkg.sv
// Shared opcodes and target state encoding for the SPI flash emulation.
package spi_flash_target_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_FAST = 8'h0B;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RPD  = 8'hAB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_FETCH,
    ST_DATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_flash_target_sync_edge.sv
// Multi-stage synchroniser with rise/fall detection on the synchronised value.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic ck,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [SYNC_STAGES:0]   vld_q, vld_d;

  // Shift the chain; edges are only reported once the chain and the history
  // flop hold real samples, so a level held through reset is not an edge.
  always_comb begin
    sync_d = (sync_q << 1) | SYNC_STAGES'(d);
    prev_d = q;
    vld_d  = (vld_q << 1) | (SYNC_STAGES + 1)'(1);
  end

  // Synchroniser, history and warm-up registers.
  always_ff @(posedge ck) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      vld_q  <= vld_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = vld_q[SYNC_STAGES] &  q & ~prev_q;
  assign fall = vld_q[SYNC_STAGES] & ~q &  prev_q;

endmodule

// File: rtl/spi_flash_target.sv
// SPI mode-0 serial NOR flash emulation: decodes READ/FAST/RDID, fetches words
// from a 1-cycle-latency memory and streams them back on miso.
module spi_flash_target
  import spi_flash_target_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MEM_AW      = 22
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              cs,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              mem_re,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              cmd_valid,
  output logic [7:0]        cmd_code,
  output logic              active
);

  logic cs_s, cs_rise, cs_fall;
  logic sck_s, sck_rise_raw, sck_fall_raw;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s, edge_ok, rise, fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .ck(ck), .rst(rst), .d(cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .ck(ck), .rst(rst), .d(sck), .q(sck_s), .rise(sck_rise_raw), .fall(sck_fall_raw)
  );

  // mosi goes through the same depth as sck so a sampled bit lines up with its rise.
  always_ff @(posedge ck) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(mosi);
  end

  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign edge_ok = ~cs_s & ~cs_rise;
  assign rise    = sck_rise_raw & edge_ok;
  assign fall    = sck_fall_raw & edge_ok;

  state_t            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [23:0]       sh_q, sh_d;
  logic [MEM_AW-1:0] word_q, word_d;
  logic [31:0]       shreg_q, shreg_d, hold_q, hold_d, nxt_word;
  logic              miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic              mem_re_q, mem_re_d, cap_q, cap_d, dst_q, dst_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        cmd_code_q, cmd_code_d;

  // Next-state, datapath and output decode.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    word_d      = word_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    nxt_word    = hold_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    cap_d       = 1'b0;
    dst_d       = dst_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;

    if (cs_s) begin
      state_d   = ST_IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end else begin
      // Read data lands one cycle after the strobe; dst selects shreg or holding reg.
      cap_d = mem_re_q;
      if (cap_q) begin
        if (dst_q) hold_d  = mem_rdata;
        else       shreg_d = mem_rdata;
      end

      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD: if (rise) begin
          sh_d      = {sh_q[22:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = sh_d[7:0];
            case (sh_d[7:0])
              CMD_READ, CMD_FAST: state_d = ST_ADDR;
              CMD_RDID: begin
                state_d = ST_DATA;
                shreg_d = {JEDEC_ID, 8'h00};
              end
              default: state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: if (rise) begin
          sh_d      = {sh_q[22:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            word_d     = MEM_AW'(sh_d[23:2]);
            mem_re_d   = 1'b1;
            mem_addr_d = word_d;
            dst_d      = 1'b0;
            state_d    = (cmd_code_q == CMD_FAST) ? ST_DUMMY : ST_FETCH;
          end
        end
        ST_DUMMY: if (rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) state_d = ST_DATA;
        end
        ST_FETCH: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd1) state_d = ST_DATA;
        end
        ST_DATA: if (fall) begin
          if (!miso_oe_q) begin
            miso_oe_d = 1'b1;
            miso_d    = shreg_q[31];
          end else if (bit_cnt_q == 5'd31) begin
            nxt_word  = (cmd_code_q == CMD_RDID) ? {JEDEC_ID, 8'h00} : hold_q;
            shreg_d   = nxt_word;
            miso_d    = nxt_word[31];
            bit_cnt_d = '0;
          end else begin
            shreg_d   = {shreg_q[30:0], 1'b0};
            miso_d    = shreg_q[30];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd15 && cmd_code_q != CMD_RDID) begin
              word_d     = word_q + MEM_AW'(1);
              mem_re_d   = 1'b1;
              mem_addr_d = word_d;
              dst_d      = 1'b1;
            end
          end
        end
        default: begin
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end
      endcase
    end

    if (state_d != state_q) bit_cnt_d = '0;
  end

  // State and datapath registers.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      word_q      <= '0;
      shreg_q     <= '0;
      hold_q      <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      cap_q       <= 1'b0;
      dst_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      word_q      <= word_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      cap_q       <= cap_d;
      dst_q       <= dst_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign active    = ~cs_s;

endmodule
